// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL-16 key loader.
// State encoding, default key width and the parity helper.
package rll_key_pkg;

    localparam int DEF_KEY_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_DONE   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // XOR-reduce; callers zero-extend, which leaves the parity unchanged.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rll_timeout_ctr.sv
// Saturating idle-cycle counter for the key loader.
// o_expired is high once the count sits at TIMEOUT-1.
module rll_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    // Clear has priority; increment stops at the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader for the RLL-16 locked netlist.
// Shifts in KEY_W bits plus even parity, commits only checked keys.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int KEY_W     = DEF_KEY_W,
    parameter int TIMEOUT   = 64,
    parameter int MAX_FAIL  = 3,
    parameter int RELOAD_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             sdi_valid,
    input  logic             sdi,
    output logic             sdi_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic             locked,
    output logic             busy
);

    localparam int CW = $clog2(KEY_W + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [CW-1:0] CNT_PAR  = CW'(KEY_W);
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAIL);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [KEY_W-1:0] r_shadow;
    logic [KEY_W-1:0] r_key;
    logic             r_par;
    logic             r_kv;
    logic             r_err;
    logic [FW-1:0]    r_fail;

    logic          w_in_shift;
    logic          w_expired;
    logic          w_tmr_clr;
    logic          w_pass;
    logic [FW-1:0] w_fail_nxt;
    logic          w_lock;

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_tmr_clr  = !w_in_shift || sdi_valid || load_start;
    assign w_pass     = !(even_par(64'(r_shadow)) ^ r_par);
    assign w_fail_nxt = r_fail + 1'b1;
    assign w_lock     = (w_fail_nxt == FAIL_LIM);

    rll_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_in_shift),
        .o_expired (w_expired)
    );

    // Frame FSM; key_out only moves on a passing check or on lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_key    <= '0;
            r_par    <= 1'b0;
            r_kv     <= 1'b0;
            r_err    <= 1'b0;
            r_fail   <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (load_start) begin
                        r_state  <= ST_SHIFT;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (load_start) begin
                        r_cnt    <= '0;
                        r_shadow <= '0;
                    end else if (sdi_valid) begin
                        if (r_cnt == CNT_PAR) begin
                            r_par   <= sdi;
                            r_state <= ST_CHECK;
                        end else begin
                            for (int i = 0; i < KEY_W; i++) begin
                                if (r_cnt == CW'(i)) r_shadow[i] <= sdi;
                            end
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_expired) begin
                        r_err  <= 1'b1;
                        r_fail <= w_fail_nxt;
                        if (w_lock) begin
                            r_state <= ST_LOCKED;
                            r_key   <= '0;
                            r_kv    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_pass) begin
                        r_key   <= r_shadow;
                        r_kv    <= 1'b1;
                        r_fail  <= '0;
                        r_state <= (RELOAD_EN != 0) ? ST_IDLE : ST_DONE;
                    end else begin
                        r_err  <= 1'b1;
                        r_fail <= w_fail_nxt;
                        if (w_lock) begin
                            r_state <= ST_LOCKED;
                            r_key   <= '0;
                            r_kv    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                ST_LOCKED: begin
                    r_key <= '0;
                    r_kv  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdi_ready = w_in_shift;
    assign busy      = w_in_shift || (r_state == ST_CHECK);
    assign locked    = (r_state == ST_LOCKED);
    assign key_out   = r_key;
    assign key_valid = r_kv;
    assign load_err  = r_err;

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed scoreboard bench for rll_key_loader.
// Runs a one-shot instance and a reload-enabled instance side by side.
module tb_rll_key_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        sdi_valid = 1'b0;
    logic        sdi = 1'b0;

    logic        sdi_ready, key_valid, load_err, locked, busy;
    logic [15:0] key_out;
    logic        r_sdi_ready, r_key_valid, r_load_err, r_locked, r_busy;
    logic [15:0] r_key_out;

    int n_chk = 0;
    int n_fail = 0;
    int err_seen = 0;
    int err_mark;

    typedef struct {
        logic [15:0] key;
        logic        kv;
        logic        err;
        logic [15:0] rkey;
        logic        rkv;
    } exp_t;

    exp_t sb[$];

    rll_key_loader #(
        .KEY_W(16), .TIMEOUT(64), .MAX_FAIL(3), .RELOAD_EN(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .sdi_valid(sdi_valid), .sdi(sdi), .sdi_ready(sdi_ready),
        .key_out(key_out), .key_valid(key_valid), .load_err(load_err),
        .locked(locked), .busy(busy)
    );

    rll_key_loader #(
        .KEY_W(16), .TIMEOUT(64), .MAX_FAIL(3), .RELOAD_EN(1)
    ) u_dut_rl (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .sdi_valid(sdi_valid), .sdi(sdi), .sdi_ready(r_sdi_ready),
        .key_out(r_key_out), .key_valid(r_key_valid), .load_err(r_load_err),
        .locked(r_locked), .busy(r_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_err === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] k, input logic p);
        for (int i = 0; i < 16; i++) begin
            sdi_valid = 1'b1;
            sdi = k[i];
            tick();
        end
        sdi = p;
        tick();
        sdi_valid = 1'b0;
        sdi = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] k, input logic p);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_bits(k, p);
    endtask

    task automatic push(input logic [15:0] k, input logic kv, input logic e,
                        input logic [15:0] rk, input logic rkv);
        exp_t x;
        x.key = k; x.kv = kv; x.err = e; x.rkey = rk; x.rkv = rkv;
        sb.push_back(x);
    endtask

    // Called right after the parity edge; result lands one edge later.
    task automatic check_frame(input string tag);
        exp_t x;
        tick();
        chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_key"}, 32'(key_out), 32'(x.key));
            chk({tag, "_kv"}, 32'(key_valid), 32'(x.kv));
            chk({tag, "_err"}, 32'(load_err), 32'(x.err));
            chk({tag, "_rkey"}, 32'(r_key_out), 32'(x.rkey));
            chk({tag, "_rkv"}, 32'(r_key_valid), 32'(x.rkv));
        end
        tick();
        chk({tag, "_err_1cyc"}, 32'(load_err), 32'd0);
    endtask

    task automatic reset_pulse();
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1;
        chk("rst_key", 32'(key_out), 32'd0);
        chk("rst_kv", 32'(key_valid), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_lock", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(sdi_ready), 32'd0);
        #11;
        rst_n = 1'b1;
        tick();

        sdi_valid = 1'b1;
        sdi = 1'b1;
        tick();
        chk("idle_ignore", 32'(busy), 32'd0);
        sdi_valid = 1'b0;

        err_mark = err_seen;
        send_frame(16'hA5C3, 1'b0);
        chk("chk_state", 32'(busy), 32'd1);
        chk("chk_kv_old", 32'(key_valid), 32'd0);
        chk("chk_rdy", 32'(sdi_ready), 32'd0);
        push(16'hA5C3, 1'b1, 1'b0, 16'hA5C3, 1'b1);
        check_frame("good");
        chk("good_no_err", 32'(err_seen - err_mark), 32'd0);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("done_rdy", 32'(sdi_ready), 32'd0);
        chk("rl_rdy", 32'(r_sdi_ready), 32'd1);
        send_bits(16'hFFFF, 1'b0);
        push(16'hA5C3, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        check_frame("reload");

        reset_pulse();
        chk("rst2_key", 32'(key_out), 32'd0);
        send_frame(16'hA5C3, 1'b1);
        push(16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
        check_frame("bad1");
        chk("bad1_busy", 32'(busy), 32'd0);
        chk("bad1_lock", 32'(locked), 32'd0);
        send_frame(16'h0F0F, 1'b1);
        push(16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
        check_frame("bad2");
        chk("bad2_lock", 32'(locked), 32'd0);
        send_frame(16'h0001, 1'b0);
        push(16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
        check_frame("bad3");
        chk("bad3_lock", 32'(locked), 32'd1);

        err_mark = err_seen;
        send_frame(16'hA5C3, 1'b0);
        tick();
        tick();
        chk("lk_key", 32'(key_out), 32'd0);
        chk("lk_kv", 32'(key_valid), 32'd0);
        chk("lk_lock", 32'(locked), 32'd1);
        chk("lk_rdy", 32'(sdi_ready), 32'd0);
        chk("lk_no_err", 32'(err_seen - err_mark), 32'd0);

        reset_pulse();
        chk("unlock", 32'(locked), 32'd0);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sdi_valid = 1'b1;
            sdi = 1'b1;
            tick();
        end
        sdi_valid = 1'b0;
        repeat (63) tick();
        chk("tmo_edge_busy", 32'(busy), 32'd1);
        chk("tmo_edge_err", 32'(load_err), 32'd0);
        tick();
        chk("tmo_err", 32'(load_err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_rerr", 32'(r_load_err), 32'd1);
        tick();
        chk("tmo_err_1cyc", 32'(load_err), 32'd0);
        send_frame(16'h1234, 1'b1);
        push(16'h1234, 1'b1, 1'b0, 16'h1234, 1'b1);
        check_frame("post_tmo");

        reset_pulse();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sdi_valid = 1'b1;
            sdi = i[0];
            tick();
        end
        sdi_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rdy", 32'(sdi_ready), 32'd0);
        chk("arst_key", 32'(key_out), 32'd0);
        chk("arst_kv", 32'(key_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sdi_valid = 1'b1;
            sdi = 1'b1;
            tick();
        end
        sdi_valid = 1'b0;
        send_frame(16'hA5C3, 1'b0);
        push(16'hA5C3, 1'b1, 1'b0, 16'hA5C3, 1'b1);
        check_frame("restart");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
